calc1_req_port: RTL and testbench

// - Initiator for one calc1 requester port: drives reqN_cmd_in/reqN_data_in and collects out_respN/out_dataN.
// - One instance per port (4 total); the local host issues (cmd, op1, op2) over valid/ready and receives code + result.
// - Serialises the calc1 two-cycle request, keeps one command outstanding, and enforces a response timeout.

---
 rtl/calc1_req_port.sv | 160 ++++++++++++++++
 tb/tb_calc1_req_port.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/calc1_req_port.sv
// Host-side initiator for one calc1 requester port: serialises a (cmd, op1, op2)
// request over two cycles, waits for the response with a timeout, and holds the completion.
module calc1_req_port #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        host_vld,
  output logic        host_rdy,
  input  logic [3:0]  host_cmd,
  input  logic [31:0] host_op1,
  input  logic [31:0] host_op2,
  output logic        rsp_vld,
  input  logic        rsp_rdy,
  output logic [1:0]  rsp_code,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic [3:0]  req_cmd,
  output logic [31:0] req_data,
  input  logic [1:0]  calc_resp,
  input  logic [31:0] calc_data,
  output logic        stray_resp
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEND1 = 3'd1;
  localparam logic [2:0] S_SEND2 = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [15:0] TMO    = 16'(TIMEOUT_CYCLES);

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] op2_q, op2_d;
  logic        host_rdy_q, host_rdy_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic [1:0]  rsp_code_q, rsp_code_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic [3:0]  req_cmd_q, req_cmd_d;
  logic [31:0] req_data_q, req_data_d;
  logic        stray_q, stray_d;

  // Outputs are computed for the state being entered, so every port comes straight from a flop.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op2_d         = op2_q;
    host_rdy_d    = 1'b0;
    rsp_vld_d     = rsp_vld_q;
    rsp_code_d    = rsp_code_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    req_cmd_d     = 4'd0;
    req_data_d    = 32'd0;
    stray_d       = (state_q != S_WAIT) && (calc_resp != 2'b00);
    case (state_q)
      S_IDLE: begin
        host_rdy_d = 1'b1;
        if (host_vld) begin
          op2_d      = host_op2;
          host_rdy_d = 1'b0;
          if (host_cmd != 4'd0) begin
            state_d    = S_SEND1;
            req_cmd_d  = host_cmd;
            req_data_d = host_op1;
          end else begin
            state_d       = S_HOLD;
            rsp_vld_d     = 1'b1;
            rsp_code_d    = 2'b10;
            rsp_data_d    = 32'd0;
            rsp_timeout_d = 1'b0;
          end
        end
      end
      S_SEND1: begin
        state_d    = S_SEND2;
        req_data_d = op2_q;
        cnt_d      = 16'd0;
      end
      S_SEND2: begin
        state_d = S_WAIT;
        cnt_d   = cnt_q + 16'd1;
      end
      S_WAIT: begin
        // A response on the final counted cycle takes priority over the timeout.
        if (calc_resp != 2'b00) begin
          state_d       = S_HOLD;
          rsp_vld_d     = 1'b1;
          rsp_code_d    = calc_resp;
          rsp_data_d    = (calc_resp == 2'b01) ? calc_data : 32'd0;
          rsp_timeout_d = 1'b0;
        end else if (cnt_q == TMO) begin
          state_d       = S_HOLD;
          rsp_vld_d     = 1'b1;
          rsp_code_d    = 2'b00;
          rsp_data_d    = 32'd0;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_HOLD: begin
        if (rsp_rdy) begin
          state_d       = S_IDLE;
          host_rdy_d    = 1'b1;
          rsp_vld_d     = 1'b0;
          rsp_code_d    = 2'b00;
          rsp_data_d    = 32'd0;
          rsp_timeout_d = 1'b0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        host_rdy_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 16'd0;
      host_rdy_q    <= 1'b1;
      rsp_vld_q     <= 1'b0;
      rsp_code_q    <= 2'b00;
      rsp_data_q    <= 32'd0;
      rsp_timeout_q <= 1'b0;
      req_cmd_q     <= 4'd0;
      req_data_q    <= 32'd0;
      stray_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      host_rdy_q    <= host_rdy_d;
      rsp_vld_q     <= rsp_vld_d;
      rsp_code_q    <= rsp_code_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      req_cmd_q     <= req_cmd_d;
      req_data_q    <= req_data_d;
      stray_q       <= stray_d;
    end
  end

  // Operand holding register carries no control meaning, so it is left out of reset.
  always_ff @(posedge c_clk) begin
    op2_q <= op2_d;
  end

  assign host_rdy    = host_rdy_q;
  assign rsp_vld     = rsp_vld_q;
  assign rsp_code    = rsp_code_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign req_cmd     = req_cmd_q;
  assign req_data    = req_data_q;
  assign stray_resp  = stray_q;

endmodule

// File: tb/tb_calc1_req_port.sv
// Scoreboard bench for calc1_req_port: expected completions queued at issue, checked on rsp_vld.
module tb_calc1_req_port;

  logic        c_clk = 1'b0;
  logic        reset;
  logic        host_vld;
  logic        host_rdy;
  logic [3:0]  host_cmd;
  logic [31:0] host_op1, host_op2;
  logic        rsp_vld, rsp_rdy;
  logic [1:0]  rsp_code;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic [3:0]  req_cmd;
  logic [31:0] req_data;
  logic [1:0]  calc_resp;
  logic [31:0] calc_data;
  logic        stray_resp;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [1:0]  code;
    logic [31:0] data;
    logic        tmo;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  calc1_req_port #(.TIMEOUT_CYCLES(8)) dut (
    .c_clk(c_clk), .reset(reset),
    .host_vld(host_vld), .host_rdy(host_rdy),
    .host_cmd(host_cmd), .host_op1(host_op1), .host_op2(host_op2),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .rsp_code(rsp_code), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .req_cmd(req_cmd), .req_data(req_data),
    .calc_resp(calc_resp), .calc_data(calc_data),
    .stray_resp(stray_resp)
  );

  always #5 c_clk = ~c_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command; calc1 answers (cresp, cdata) in cycle T+k (k=0: never).
  task automatic run_txn(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                         input logic [1:0] cresp, input logic [31:0] cdata, input int k,
                         input exp_t e, input int hold);
    exp_t got;
    bit   seen = 0;
    sb_q.push_back(e);
    @(negedge c_clk);
    chk("host_rdy_idle", host_rdy, 1'b1);
    host_vld = 1'b1; host_cmd = cmd; host_op1 = op1; host_op2 = op2;
    @(posedge c_clk);
    #1 host_vld = 1'b0; host_cmd = 4'd0; host_op1 = 32'd0; host_op2 = 32'd0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(negedge c_clk);
      if (cyc == 1) begin
        chk("req_cmd_c1", req_cmd, cmd);
        chk("req_data_c1", req_data, (cmd != 0) ? op1 : 32'd0);
      end
      if (cyc == 2) begin
        chk("req_cmd_c2", req_cmd, 4'd0);
        chk("req_data_c2", req_data, (cmd != 0) ? op2 : 32'd0);
      end
      if (rsp_vld === 1'b1) begin
        seen = 1;
        calc_resp = 2'b00; calc_data = 32'd0;
        if (sb_q.size() == 0) chk("sb_empty", 1, 0);
        else begin
          got = sb_q.pop_front();
          chk("latency", 64'(cyc), 64'(got.lat));
          chk("rsp_code", rsp_code, got.code);
          chk("rsp_data", rsp_data, got.data);
          chk("rsp_timeout", rsp_timeout, got.tmo);
          for (int h = 0; h < hold; h++) begin
            @(negedge c_clk);
            chk("hold_vld", rsp_vld, 1'b1);
            chk("hold_rdy", host_rdy, 1'b0);
            chk("hold_code", rsp_code, got.code);
            chk("hold_data", rsp_data, got.data);
            chk("hold_req", req_cmd, 4'd0);
          end
        end
        rsp_rdy = 1'b1;
        @(posedge c_clk);
        #1 rsp_rdy = 1'b0;
        @(negedge c_clk);
        chk("vld_drop", rsp_vld, 1'b0);
        chk("rdy_back", host_rdy, 1'b1);
      end else begin
        calc_resp = (cyc == k) ? cresp : 2'b00;
        calc_data = (cyc == k) ? cdata : 32'hDEAD_BEEF;
      end
    end
    if (!seen) chk("rsp_wait_bound", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got stuck expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; host_vld = 1'b0; host_cmd = 4'd0; host_op1 = 32'd0; host_op2 = 32'd0;
    rsp_rdy = 1'b0; calc_resp = 2'b00; calc_data = 32'd0;
    repeat (3) @(posedge c_clk);
    @(negedge c_clk);
    chk("rst_host_rdy", host_rdy, 1'b1);
    chk("rst_rsp_vld", rsp_vld, 1'b0);
    chk("rst_req_cmd", req_cmd, 4'd0);
    chk("rst_req_data", req_data, 32'd0);
    chk("rst_rsp_code", rsp_code, 2'b00);
    chk("rst_stray", stray_resp, 1'b0);
    reset = 1'b0;

    // add, minimum latency
    run_txn(4'd1, 32'd5, 32'd3, 2'b01, 32'd8, 3, '{code:2'b01, data:32'd8, tmo:1'b0, lat:4}, 0);
    // overflow: data dropped
    run_txn(4'd1, 32'hFFFF_FFFF, 32'd1, 2'b10, 32'h1234_5678, 5,
            '{code:2'b10, data:32'd0, tmo:1'b0, lat:6}, 0);
    // sub with internal error code
    run_txn(4'd2, 32'd9, 32'd4, 2'b11, 32'h5, 4, '{code:2'b11, data:32'd0, tmo:1'b0, lat:5}, 0);
    // timeout: WAIT cycles T+3..T+10 counted 1..8
    run_txn(4'd5, 32'd1, 32'd4, 2'b00, 32'd0, 0, '{code:2'b00, data:32'd0, tmo:1'b1, lat:11}, 0);

    // late response after timeout -> stray pulse only
    @(negedge c_clk);
    calc_resp = 2'b01; calc_data = 32'h77;
    @(negedge c_clk);
    calc_resp = 2'b00;
    chk("stray_pulse", stray_resp, 1'b1);
    chk("stray_no_vld", rsp_vld, 1'b0);
    @(negedge c_clk);
    chk("stray_clear", stray_resp, 1'b0);

    // response on the last counted WAIT cycle wins
    run_txn(4'd6, 32'h100, 32'd2, 2'b01, 32'h40, 10, '{code:2'b01, data:32'h40, tmo:1'b0, lat:11}, 0);
    // no-op command with backpressure
    run_txn(4'd0, 32'hAAAA, 32'hBBBB, 2'b00, 32'd0, 0, '{code:2'b10, data:32'd0, tmo:1'b0, lat:1}, 20);
    // shl with backpressure, random operands
    begin
      logic [31:0] a, d;
      a = $urandom; d = $urandom;
      run_txn(4'd5, a, 32'd3, 2'b01, d, 7, '{code:2'b01, data:d, tmo:1'b0, lat:8}, 20);
    end

    // reset while in WAIT aborts with no completion
    @(negedge c_clk);
    host_vld = 1'b1; host_cmd = 4'd1; host_op1 = 32'd1; host_op2 = 32'd2;
    @(posedge c_clk);
    #1 host_vld = 1'b0;
    repeat (4) @(negedge c_clk);
    reset = 1'b1;
    @(posedge c_clk);
    #1 reset = 1'b0;
    @(negedge c_clk);
    chk("wrst_host_rdy", host_rdy, 1'b1);
    chk("wrst_rsp_vld", rsp_vld, 1'b0);
    chk("wrst_req_cmd", req_cmd, 4'd0);
    chk("wrst_rsp_tmo", rsp_timeout, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge c_clk);
      chk("wrst_no_cpl", rsp_vld, 1'b0);
    end
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
